// File: rtl/ngs_cfg_pkg.sv
// Shared configuration for the FPGA passive-serial loader: state encoding and parameter defaults.
package ngs_cfg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_TAIL,
      ST_DONE,
      ST_ERROR
   } ps_state_e;

   localparam int unsigned DCLK_DIV_DEF  = 2;
   localparam int unsigned TAIL_CLKS_DEF = 10;

   localparam logic [19:0] BYTECNT_MAX = 20'hFFFFF;

   function automatic logic [19:0] sat_inc20(input logic [19:0] v);
      return (v == BYTECNT_MAX) ? v : v + 20'd1;
   endfunction

endpackage

// File: rtl/ps_fifo2.sv
// Two-entry byte FIFO with synchronous flush; push while full and pop while empty are ignored.
module ps_fifo2 (
   input  logic       clk,
   input  logic       rst,
   input  logic       flush,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);

   logic [1:0][7:0] mem_q, mem_d;
   logic [1:0]      count_q, count_d;
   logic            rd_q, rd_d;
   logic            wr_q, wr_d;
   logic            push_ok, pop_ok;

   assign full  = (count_q == 2'd2);
   assign empty = (count_q == 2'd0);
   assign dout  = mem_q[rd_q];

   // Fullness is judged on the registered count, so a same-cycle pop never frees room for a push.
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;

   always_comb begin
      mem_d   = mem_q;
      count_d = count_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      if (flush) begin
         count_d = '0;
         rd_d    = 1'b0;
         wr_d    = 1'b0;
      end else begin
         if (push_ok) begin
            mem_d[wr_q] = din;
            wr_d        = ~wr_q;
         end
         if (pop_ok) begin
            rd_d = ~rd_q;
         end
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q   <= '0;
         count_q <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
      end else begin
         mem_q   <= mem_d;
         count_q <= count_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
      end
   end

endmodule

// File: rtl/fpga_ps_loader.sv
// Passive-serial FPGA configuration loader fed by CPU byte writes through a 2-entry FIFO.
// Optional output bytecnt is present when FPGA_PS_LOADER_BYTECNT_EN is defined.
module fpga_ps_loader
   import ngs_cfg_pkg::*;
#(
   parameter int unsigned DCLK_DIV  = DCLK_DIV_DEF,
   parameter int unsigned TAIL_CLKS = TAIL_CLKS_DEF
) (
   input  logic        clkin,
   input  logic        coldres,
   input  logic        config_n,
   input  logic        status_n,
   input  logic        conf_done,
   input  logic        wr_stb,
   input  logic [7:0]  wr_data,
   output logic        dclk,
   output logic        data0,
   output logic        busy,
   output logic        ovf,
   output logic        err,
   output logic        done
`ifdef FPGA_PS_LOADER_BYTECNT_EN
   ,
   output logic [19:0] bytecnt
`endif
);

   localparam logic [3:0] DIV_RELOAD = 4'(DCLK_DIV - 1);
   localparam logic [4:0] TAIL_LAST  = 5'(TAIL_CLKS - 1);

   ps_state_e  state_q, state_d;
   logic [7:0] sr_q, sr_d;
   logic [2:0] bit_q, bit_d;
   logic [3:0] div_q, div_d;
   logic [4:0] tail_q, tail_d;
   logic       dclk_q, dclk_d;
   logic       data0_q, data0_d;
   logic       ovf_q, ovf_d;
   logic       err_q, err_d;
   logic       done_q, done_d;

   logic       fifo_flush, fifo_push, fifo_pop;
   logic [7:0] fifo_dout;
   logic       fifo_full, fifo_empty;

`ifdef FPGA_PS_LOADER_BYTECNT_EN
   logic [19:0] bytecnt_q, bytecnt_d;
   assign bytecnt = bytecnt_q;
`endif

   ps_fifo2 u_fifo (
      .clk   (clkin),
      .rst   (coldres),
      .flush (fifo_flush),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (wr_data),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign dclk  = dclk_q;
   assign data0 = data0_q;
   assign ovf   = ovf_q;
   assign err   = err_q;
   assign done  = done_q;
   assign busy  = fifo_full | ((state_q != ST_IDLE) & (state_q != ST_DONE));

   always_comb begin
      state_d    = state_q;
      sr_d       = sr_q;
      bit_d      = bit_q;
      div_d      = div_q;
      tail_d     = tail_q;
      dclk_d     = dclk_q;
      data0_d    = data0_q;
      ovf_d      = ovf_q;
      err_d      = err_q;
      done_d     = done_q;
      fifo_flush = 1'b0;
      fifo_push  = 1'b0;
      fifo_pop   = 1'b0;
`ifdef FPGA_PS_LOADER_BYTECNT_EN
      bytecnt_d  = bytecnt_q;
`endif

      if (!config_n) begin
         fifo_flush = 1'b1;
         state_d    = ST_IDLE;
         sr_d       = '0;
         bit_d      = '0;
         div_d      = '0;
         tail_d     = '0;
         dclk_d     = 1'b0;
         data0_d    = 1'b1;
         ovf_d      = 1'b0;
         err_d      = 1'b0;
         done_d     = 1'b0;
`ifdef FPGA_PS_LOADER_BYTECNT_EN
         bytecnt_d  = '0;
`endif
      end else begin
         if (wr_stb && (state_q != ST_DONE)) begin
            if (fifo_full) ovf_d = 1'b1;
            else           fifo_push = 1'b1;
         end

         case (state_q)
            ST_IDLE: begin
               if (conf_done) begin
                  state_d = ST_TAIL;
                  tail_d  = '0;
                  div_d   = DIV_RELOAD;
                  dclk_d  = 1'b0;
                  data0_d = 1'b1;
               end else if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  state_d  = ST_SHIFT;
                  sr_d     = fifo_dout;
                  data0_d  = fifo_dout[0];
                  bit_d    = '0;
                  div_d    = DIV_RELOAD;
                  dclk_d   = 1'b0;
               end
            end

            ST_SHIFT: begin
               if (!status_n) begin
                  state_d = ST_ERROR;
                  err_d   = 1'b1;
                  dclk_d  = 1'b0;
               end else if (div_q != 4'd0) begin
                  div_d = div_q - 4'd1;
               end else begin
                  div_d = DIV_RELOAD;
                  if (!dclk_q) begin
                     dclk_d = 1'b1;
                  end else if (bit_q != 3'd7) begin
                     dclk_d  = 1'b0;
                     bit_d   = bit_q + 3'd1;
                     sr_d    = {1'b0, sr_q[7:1]};
                     data0_d = sr_q[1];
                  end else begin
                     // Byte boundary: conf_done wins over a queued byte.
                     dclk_d = 1'b0;
                     bit_d  = '0;
`ifdef FPGA_PS_LOADER_BYTECNT_EN
                     bytecnt_d = sat_inc20(bytecnt_q);
`endif
                     if (conf_done) begin
                        state_d = ST_TAIL;
                        tail_d  = '0;
                        data0_d = 1'b1;
                     end else if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        sr_d     = fifo_dout;
                        data0_d  = fifo_dout[0];
                     end else begin
                        state_d = ST_IDLE;
                     end
                  end
               end
            end

            ST_TAIL: begin
               data0_d = 1'b1;
               if (!status_n) begin
                  state_d = ST_ERROR;
                  err_d   = 1'b1;
                  dclk_d  = 1'b0;
               end else if (div_q != 4'd0) begin
                  div_d = div_q - 4'd1;
               end else begin
                  div_d = DIV_RELOAD;
                  if (!dclk_q) begin
                     dclk_d = 1'b1;
                  end else if (tail_q == TAIL_LAST) begin
                     dclk_d  = 1'b0;
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end else begin
                     dclk_d = 1'b0;
                     tail_d = tail_q + 5'd1;
                  end
               end
            end

            ST_DONE: begin
               dclk_d  = 1'b0;
               data0_d = 1'b1;
            end

            ST_ERROR: begin
               dclk_d = 1'b0;
            end

            default: begin
               state_d = ST_IDLE;
               dclk_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clkin or posedge coldres) begin
      if (coldres) begin
         state_q   <= ST_IDLE;
         sr_q      <= '0;
         bit_q     <= '0;
         div_q     <= '0;
         tail_q    <= '0;
         dclk_q    <= 1'b0;
         data0_q   <= 1'b1;
         ovf_q     <= 1'b0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
`ifdef FPGA_PS_LOADER_BYTECNT_EN
         bytecnt_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         sr_q      <= sr_d;
         bit_q     <= bit_d;
         div_q     <= div_d;
         tail_q    <= tail_d;
         dclk_q    <= dclk_d;
         data0_q   <= data0_d;
         ovf_q     <= ovf_d;
         err_q     <= err_d;
         done_q    <= done_d;
`ifdef FPGA_PS_LOADER_BYTECNT_EN
         bytecnt_q <= bytecnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_fpga_ps_loader.sv
// Self-checking bench for fpga_ps_loader: captured DCLK/DATA0 stream compared against expected byte queue.
module tb_fpga_ps_loader;

   localparam int unsigned DIV  = 2;
   localparam int unsigned TAIL = 10;

   logic       clkin     = 1'b0;
   logic       coldres   = 1'b0;
   logic       config_n  = 1'b1;
   logic       status_n  = 1'b1;
   logic       conf_done = 1'b0;
   logic       wr_stb    = 1'b0;
   logic [7:0] wr_data   = '0;
   logic       dclk, data0, busy, ovf, err, done;
`ifdef FPGA_PS_LOADER_BYTECNT_EN
   logic [19:0] bytecnt;
`endif

   fpga_ps_loader #(.DCLK_DIV(DIV), .TAIL_CLKS(TAIL)) dut (
      .clkin     (clkin),
      .coldres   (coldres),
      .config_n  (config_n),
      .status_n  (status_n),
      .conf_done (conf_done),
      .wr_stb    (wr_stb),
      .wr_data   (wr_data),
      .dclk      (dclk),
      .data0     (data0),
      .busy      (busy),
      .ovf       (ovf),
      .err       (err),
      .done      (done)
`ifdef FPGA_PS_LOADER_BYTECNT_EN
      ,
      .bytecnt   (bytecnt)
`endif
   );

   always #5 clkin = ~clkin;

   int cyc = 0;
   always @(posedge clkin) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Monitor: every DCLK rising edge captures DATA0; DATA0 must hold while DCLK is high.
   logic cap_bits[$];
   int   cap_cyc[$];
   logic dclk_prev  = 1'b0;
   logic data0_prev = 1'b1;
   always @(negedge clkin) begin
      if (dclk === 1'b1 && dclk_prev === 1'b0) begin
         cap_bits.push_back(data0);
         cap_cyc.push_back(cyc);
      end
      if (dclk === 1'b1 && dclk_prev === 1'b1) check("data0_stable_hi", data0, data0_prev);
      dclk_prev  <= dclk;
      data0_prev <= data0;
   end

   logic [7:0] exp_bytes[$];

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clkin);
         #1;
      end
   endtask

   task automatic write_byte(input logic [7:0] b);
      wr_data = b;
      wr_stb  = 1'b1;
      tick(1);
      wr_stb  = 1'b0;
   endtask

   task automatic clear_cap();
      cap_bits.delete();
      cap_cyc.delete();
      exp_bytes.delete();
   endtask

   task automatic wait_rises(input string tag, input int n);
      int k = 0;
      while (cap_bits.size() < n && k < 1000) begin
         tick(1);
         k++;
      end
      check(tag, (cap_bits.size() >= n), 1);
   endtask

   task automatic wait_idle(input string tag);
      int run = 0;
      int k   = 0;
      while (run < 3 && k < 3000) begin
         tick(1);
         k++;
         if (busy === 1'b0) run++;
         else run = 0;
      end
      check(tag, (run >= 3), 1);
   endtask

   task automatic check_stream(input string tag);
      logic [7:0] got;
      check({tag, "_nbits"}, cap_bits.size(), exp_bytes.size() * 8);
      for (int i = 0; i < exp_bytes.size(); i++) begin
         for (int b = 0; b < 8; b++) begin
            if (i * 8 + b < cap_bits.size()) got[b] = cap_bits[i * 8 + b];
            else got[b] = 1'bx;
         end
         check({tag, "_byte"}, got, exp_bytes[i]);
      end
   endtask

   task automatic check_spacing(input string tag);
      int bad = 0;
      for (int i = 1; i < cap_cyc.size(); i++)
         if (cap_cyc[i] - cap_cyc[i - 1] != 2 * DIV) bad++;
      check(tag, bad, 0);
   endtask

   task automatic config_pulse();
      config_n = 1'b0;
      tick(1);
      config_n = 1'b1;
   endtask

   initial begin
      int n;
      int s0;
      int ones;
      logic [7:0] b;

      // Reset state
      #2 coldres = 1'b1;
      #1;
      check("rst_dclk", dclk, 1'b0);
      check("rst_data0", data0, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_ovf", ovf, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_done", done, 1'b0);
`ifdef FPGA_PS_LOADER_BYTECNT_EN
      check("rst_bytecnt", bytecnt, 20'd0);
`endif
      tick(2);
      coldres = 1'b0;
      tick(2);

      // Single byte A5: LSB-first bits, 4-cycle DCLK periods, busy for 32 cycles
      clear_cap();
      write_byte(8'hA5);
      exp_bytes.push_back(8'hA5);
      check("a5_busy_pre", busy, 1'b0);
      n = 0;
      tick(1);
      while (busy === 1'b1 && n < 100) begin
         n++;
         tick(1);
      end
      check("a5_busy_cycles", n, 32);
      check_stream("a5");
      check_spacing("a5_spacing");
      check("a5_dclk_idle", dclk, 1'b0);

      // Back-to-back writes fill FIFO; fourth overflows; stream has no gaps
      clear_cap();
      write_byte(8'h01);
      write_byte(8'h02);
      write_byte(8'h03);
      exp_bytes.push_back(8'h01);
      exp_bytes.push_back(8'h02);
      exp_bytes.push_back(8'h03);
      check("b2b_ovf_clear", ovf, 1'b0);
      check("b2b_busy_full", busy, 1'b1);
      write_byte(8'h04);
      check("b2b_ovf_set", ovf, 1'b1);
      wait_idle("b2b_idle");
      check_stream("b2b");
      check_spacing("b2b_no_gap");
      check("b2b_ovf_sticky", ovf, 1'b1);
      config_pulse();
      check("b2b_ovf_cleared", ovf, 1'b0);

      // Randomized batches of 1..3 bytes with random write gaps
      for (int t = 0; t < 4; t++) begin
         clear_cap();
         n = $urandom_range(1, 3);
         for (int j = 0; j < n; j++) begin
            b = 8'($urandom);
            write_byte(b);
            exp_bytes.push_back(b);
            tick($urandom_range(0, 20));
         end
         wait_idle("rnd_idle");
         check_stream("rnd");
         check("rnd_ovf", ovf, 1'b0);
      end

      // conf_done mid-byte: byte completes, then TAIL pulses with data0=1, then DONE
      clear_cap();
      b = 8'($urandom);
      write_byte(b);
      exp_bytes.push_back(b);
      wait_rises("cd_rises", 3);
      conf_done = 1'b1;
      n = 0;
      while (done !== 1'b1 && n < 2000) begin
         tick(1);
         n++;
      end
      check("cd_done", done, 1'b1);
      check("cd_total_rises", cap_bits.size(), 8 + TAIL);
      ones = 0;
      for (int i = 8; i < cap_bits.size(); i++) if (cap_bits[i] === 1'b1) ones++;
      check("cd_tail_ones", ones, TAIL);
      exp_bytes.delete();
      exp_bytes.push_back(b);
      begin
         logic [7:0] got;
         for (int i = 0; i < 8; i++) got[i] = (i < cap_bits.size()) ? cap_bits[i] : 1'bx;
         check("cd_byte", got, b);
      end
      check_spacing("cd_spacing");
      check("cd_dclk", dclk, 1'b0);
      check("cd_data0", data0, 1'b1);
      check("cd_busy", busy, 1'b0);
      s0 = cap_bits.size();
      write_byte(8'h11);
      write_byte(8'h22);
      write_byte(8'h33);
      tick(40);
      check("done_discard_ovf", ovf, 1'b0);
      check("done_discard_busy", busy, 1'b0);
      check("done_discard_rises", cap_bits.size(), s0);
      conf_done = 1'b0;
      config_pulse();
      check("cd_done_cleared", done, 1'b0);

      // nSTATUS low during SHIFT: ERROR, then config_n pulse recovers with flushed FIFO
      clear_cap();
      write_byte(8'($urandom));
      write_byte(8'($urandom));
      wait_rises("st_rises", 2);
      status_n = 1'b0;
      tick(1);
      check("st_err", err, 1'b1);
      check("st_dclk", dclk, 1'b0);
      check("st_busy", busy, 1'b1);
      s0 = cap_bits.size();
      tick(8);
      check("st_hold_err", err, 1'b1);
      check("st_hold_rises", cap_bits.size(), s0);
      config_pulse();
      check("st_err_cleared", err, 1'b0);
      check("st_busy_cleared", busy, 1'b0);
      status_n = 1'b1;
      tick(60);
      check("st_fifo_flushed", cap_bits.size(), s0);

      // coldres mid-byte forces outputs asynchronously
      clear_cap();
      write_byte(8'($urandom));
      write_byte(8'($urandom));
      wait_rises("cr_rises", 3);
      #3 coldres = 1'b1;
      #1;
      check("cr_dclk", dclk, 1'b0);
      check("cr_data0", data0, 1'b1);
      check("cr_busy", busy, 1'b0);
      check("cr_done", done, 1'b0);
`ifdef FPGA_PS_LOADER_BYTECNT_EN
      check("cr_bytecnt", bytecnt, 20'd0);
`endif
      tick(2);
      coldres = 1'b0;
      s0 = cap_bits.size();
      tick(60);
      check("cr_no_activity", cap_bits.size(), s0);

      clear_cap();
      for (int j = 0; j < 3; j++) begin
         b = 8'($urandom);
         write_byte(b);
         exp_bytes.push_back(b);
      end
      wait_idle("cr3_idle");
      check_stream("cr3");
`ifdef FPGA_PS_LOADER_BYTECNT_EN
      check("cr3_bytecnt", bytecnt, 20'd3);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fpga_ps_loader.md
FPGA_PS_LOADER -- requirements
Module: fpga_ps_loader

Interface
REQ-001 SHALL have parameter DCLK_DIV, default 2, meaning clkin cycles per DCLK half-period (legal 1..15).
REQ-002 SHALL have parameter TAIL_CLKS, default 10, meaning extra DCLK pulses issued after conf_done rises (legal 1..31).
REQ-003 SHALL have port clkin, input, width 1: sole clock, all state on its rising edge.
REQ-004 SHALL have port coldres, input, width 1: asynchronous active-high reset.
REQ-005 SHALL have port config_n, input, width 1: FPGA nCONFIG as driven by the paging/config CPLD; low = abort/restart.
REQ-006 SHALL have port status_n, input, width 1: FPGA nSTATUS, already synchronised.
REQ-007 SHALL have port conf_done, input, width 1: FPGA CONF_DONE, already synchronised.
REQ-008 SHALL have port wr_stb, input, width 1: one-cycle pulse, byte present on wr_data.
REQ-009 SHALL have port wr_data, input, width 8: configuration byte written by Z80 (port {a7,a6}=11).
REQ-010 SHALL have port dclk, output, width 1: PS-mode DCLK to FPGA.
REQ-011 SHALL have port data0, output, width 1: PS-mode DATA0 to FPGA.
REQ-012 SHALL have port busy, output, width 1: high when FIFO full or state not IDLE/DONE.
REQ-013 SHALL have port ovf, output, width 1: sticky, write dropped because FIFO full.
REQ-014 SHALL have port err, output, width 1: sticky, nSTATUS went low during load.
REQ-015 SHALL have port done, output, width 1: high in DONE state.

Function
REQ-016 SHALL buffer bytes in a 2-entry FIFO; wr_stb while full drops the byte and sets ovf; fullness is evaluated before any same-cycle pop.
REQ-017 SHALL use states IDLE, SHIFT, TAIL, DONE, ERROR.
REQ-018 IDLE: when FIFO non-empty and config_n=1, SHALL pop one byte into the shift register next cycle and enter SHIFT.
REQ-019 SHIFT: SHALL send bits LSB first; data0 changes only while dclk=0; dclk low for DCLK_DIV cycles then high for DCLK_DIV cycles per bit; one byte = 16*DCLK_DIV cycles.
REQ-020 After bit 7's high phase: SHALL pop next byte with no gap if FIFO non-empty, else return to IDLE with dclk=0.
REQ-021 conf_done=1 seen in IDLE or at a byte boundary SHALL enter TAIL; TAIL issues TAIL_CLKS full DCLK periods with data0=1, then enters DONE.
REQ-022 DONE: SHALL hold dclk=0, data0=1, discard incoming FIFO writes without setting ovf.
REQ-023 status_n=0 while config_n=1 in SHIFT or TAIL SHALL enter ERROR next cycle, set err, dclk=0; ERROR holds until config_n=0.
REQ-024 config_n=0 in any state SHALL, next cycle: flush FIFO, clear shift register, bit and tail counters, go IDLE, dclk=0; ovf and err clear; done low.
REQ-025 Bit counter SHALL be 3 bits wrapping 7->0 at byte end; divider counter SHALL reload to DCLK_DIV-1 at each phase boundary.

Reset
REQ-026 coldres=1 SHALL asynchronously force: state IDLE, FIFO empty, dclk=0, data0=1, busy=0, ovf=0, err=0, done=0, all counters 0.
REQ-027 Release of coldres SHALL take effect on the first clkin rising edge after deassertion; no output glitch during release.

Configuration
REQ-028 With FPGA_PS_LOADER_BYTECNT_EN defined, SHALL add output bytecnt[19:0] counting bytes fully shifted since last config_n=0 or reset, saturating at 20'hFFFFF.
REQ-029 Without FPGA_PS_LOADER_BYTECNT_EN, bytecnt port and counter SHALL not exist; all other behaviour identical.

Structure
REQ-030 State encoding enum and DCLK_DIV/TAIL_CLKS defaults SHALL live in shared package ngs_cfg_pkg.
REQ-031 FIFO SHALL be sub-module ps_fifo2 (2x8, push/pop/full/empty, flush input); shifter FSM stays in top.

Verification
REQ-032 DCLK_DIV=2, write 8'hA5 in IDLE -> 8 dclk pulses of 4 cycles, data0 on rising edges = 1,0,1,0,0,1,0,1; busy low after 32 cycles.
REQ-033 Three back-to-back wr_stb (8'h01,8'h02,8'h03) at first SHIFT cycle -> FIFO holds all three (one already in shift register), no gap in dclk, ovf=0; fourth immediate write -> ovf=1.
REQ-034 conf_done rises mid-byte -> byte completes, then exactly 10 dclk pulses with data0=1, done=1.
REQ-035 status_n=0 during SHIFT -> err=1 and dclk=0 next cycle; config_n pulse low -> err=0, IDLE, FIFO empty.
REQ-036 coldres asserted mid-byte -> dclk=0, data0=1, busy=0 immediately (asynchronously); with BYTECNT_EN, bytecnt=0 and after 3 bytes reads 3.
